// File: rtl/operand_fetch_pkg.sv
// Shared types and ALU control constants for the operand-fetch stage.
// The ALU_CTL_* encodings are only consumed by the test bench; the stage never decodes ctl.
package operand_fetch_pkg;

  localparam int ALU_CTLW = 16;

  localparam logic [ALU_CTLW-1:0] ALU_CTL_ADD  = 16'h0001;
  localparam logic [ALU_CTLW-1:0] ALU_CTL_SUB  = 16'h0002;
  localparam logic [ALU_CTLW-1:0] ALU_CTL_AND  = 16'h0004;
  localparam logic [ALU_CTLW-1:0] ALU_CTL_OR   = 16'h0008;
  localparam logic [ALU_CTLW-1:0] ALU_CTL_XOR  = 16'h0010;
  localparam logic [ALU_CTLW-1:0] ALU_CTL_SLL  = 16'h0020;
  localparam logic [ALU_CTLW-1:0] ALU_CTL_SRL  = 16'h0040;
  localparam logic [ALU_CTLW-1:0] ALU_CTL_SRA  = 16'h0080;
  localparam logic [ALU_CTLW-1:0] ALU_CTL_SLT  = 16'h0100;
  localparam logic [ALU_CTLW-1:0] ALU_CTL_SLTU = 16'h0200;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/operand_fetch_regfile_2r1w.sv
// 2**AW x XLEN register file: two combinational read ports, one synchronous write port.
// x0 is never written and always reads as zero.
module regfile_2r1w #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [2**AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data1 = (rd_addr1 == '0) ? '0 : mem[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : mem[rd_addr2];

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage feeding the ALU through a 2-entry skid buffer (head + skid).
// OPERAND_FETCH_FWD_EN: write-through bypass of same-cycle writeback into reads and buffered entries.
//
// state    | meaning
// ST_EMPTY | no op held, out_valid=0
// ST_ONE   | head valid, skid free
// ST_FULL  | head and skid valid, in_ready=0
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int CTLW = ALU_CTLW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CTLW-1:0] in_ctl,
  input  logic [AW-1:0]   in_rs1,
  input  logic [AW-1:0]   in_rs2,
  input  logic            in_use_imm,
  input  logic [XLEN-1:0] in_imm,
  input  logic [AW-1:0]   in_rd,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CTLW-1:0] out_ctl,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [AW-1:0]   out_rd
);

`ifdef OPERAND_FETCH_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  buf_state_t      state;
  logic [CTLW-1:0] h_ctl, s_ctl;
  logic [XLEN-1:0] h_op1, h_op2, s_op1, s_op2;
  logic [AW-1:0]   h_rs1, h_rs2, h_rd, s_rs1, s_rs2, s_rd;
  logic            h_imm, s_imm;

  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [XLEN-1:0] new_op1, new_op2;
  logic [XLEN-1:0] h_op1_p, h_op2_p, s_op1_p, s_op2_p;
  logic            accept, consume, wb_live;

  regfile_2r1w #(.XLEN(XLEN), .AW(AW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr1 (in_rs1),
    .rd_addr2 (in_rs2),
    .rd_data1 (rf_rd1),
    .rd_data2 (rf_rd2),
    .wr_en    (wb_en),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // With the bypass disabled wb_live is constant 0 and every patch mux collapses to the stored value.
  assign wb_live = FWD_EN && wb_en && (wb_rd != '0);

  assign new_op1 = (wb_live && (wb_rd == in_rs1)) ? wb_data : rf_rd1;
  assign new_op2 = in_use_imm ? in_imm :
                   ((wb_live && (wb_rd == in_rs2)) ? wb_data : rf_rd2);

  assign h_op1_p = (wb_live && (wb_rd == h_rs1)) ? wb_data : h_op1;
  assign h_op2_p = (wb_live && !h_imm && (wb_rd == h_rs2)) ? wb_data : h_op2;
  assign s_op1_p = (wb_live && (wb_rd == s_rs1)) ? wb_data : s_op1;
  assign s_op2_p = (wb_live && !s_imm && (wb_rd == s_rs2)) ? wb_data : s_op2;

  assign out_ctl = h_ctl;
  assign out_op1 = h_op1;
  assign out_op2 = h_op2;
  assign out_rd  = h_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      h_ctl <= '0; h_op1 <= '0; h_op2 <= '0; h_rs1 <= '0; h_rs2 <= '0; h_rd <= '0; h_imm <= 1'b0;
      s_ctl <= '0; s_op1 <= '0; s_op2 <= '0; s_rs1 <= '0; s_rs2 <= '0; s_rd <= '0; s_imm <= 1'b0;
    end else begin
      h_op1 <= h_op1_p;
      h_op2 <= h_op2_p;
      s_op1 <= s_op1_p;
      s_op2 <= s_op2_p;
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            h_ctl <= in_ctl; h_op1 <= new_op1; h_op2 <= new_op2;
            h_rs1 <= in_rs1; h_rs2 <= in_rs2; h_imm <= in_use_imm; h_rd <= in_rd;
            state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            h_ctl <= in_ctl; h_op1 <= new_op1; h_op2 <= new_op2;
            h_rs1 <= in_rs1; h_rs2 <= in_rs2; h_imm <= in_use_imm; h_rd <= in_rd;
          end else if (accept) begin
            s_ctl <= in_ctl; s_op1 <= new_op1; s_op2 <= new_op2;
            s_rs1 <= in_rs1; s_rs2 <= in_rs2; s_imm <= in_use_imm; s_rd <= in_rd;
            state <= ST_FULL;
          end else if (consume) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            h_ctl <= s_ctl; h_op1 <= s_op1_p; h_op2 <= s_op2_p;
            h_rs1 <= s_rs1; h_rs2 <= s_rs2; h_imm <= s_imm; h_rd <= s_rd;
            state <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomised self-checking bench for operand_fetch against a queue/array reference model.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int CTLW = ALU_CTLW;

`ifdef OPERAND_FETCH_FWD_EN
  localparam bit FWD = 1'b1;
  localparam logic [31:0] HAZ_EXP = 32'h8CBDA0FC;
`else
  localparam bit FWD = 1'b0;
  localparam logic [31:0] HAZ_EXP = 32'h0097423B;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CTLW-1:0] in_ctl = '0;
  logic [AW-1:0]   in_rs1 = '0;
  logic [AW-1:0]   in_rs2 = '0;
  logic            in_use_imm = 1'b0;
  logic [XLEN-1:0] in_imm = '0;
  logic [AW-1:0]   in_rd = '0;
  logic            wb_en = 1'b0;
  logic [AW-1:0]   wb_rd = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [CTLW-1:0] out_ctl;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [AW-1:0]   out_rd;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctl(in_ctl),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_imm(in_use_imm),
    .in_imm(in_imm), .in_rd(in_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctl(out_ctl),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd)
  );

  typedef struct {
    logic [CTLW-1:0] ctl;
    logic [31:0]     op1;
    logic [31:0]     op2;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            use_imm;
  } op_t;

  op_t         q[$];
  logic [31:0] rf[32];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] rf_read(logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (FWD && wb_en && (wb_rd == r)) return wb_data;
    return rf[r];
  endfunction

  // Advance model and DUT by one clock using the currently driven inputs.
  task automatic tick();
    bit  acc, con;
    op_t e;
    acc = in_valid && (q.size() < 2);
    con = (q.size() > 0) && out_ready;
    if (con) q.delete(0);
    if (FWD && wb_en && (wb_rd != 5'd0)) begin
      foreach (q[i]) begin
        if (q[i].rs1 == wb_rd) q[i].op1 = wb_data;
        if (!q[i].use_imm && (q[i].rs2 == wb_rd)) q[i].op2 = wb_data;
      end
    end
    if (acc) begin
      e.ctl = in_ctl; e.rd = in_rd; e.rs1 = in_rs1; e.rs2 = in_rs2; e.use_imm = in_use_imm;
      e.op1 = rf_read(in_rs1);
      e.op2 = in_use_imm ? in_imm : rf_read(in_rs2);
      q.push_back(e);
    end
    if (wb_en && (wb_rd != 5'd0)) rf[wb_rd] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  endtask

  task automatic set_op(logic [CTLW-1:0] ctl, logic [4:0] rs1, logic [4:0] rs2,
                        logic use_imm, logic [31:0] imm, logic [4:0] rd);
    in_valid = 1'b1; in_ctl = ctl; in_rs1 = rs1; in_rs2 = rs2;
    in_use_imm = use_imm; in_imm = imm; in_rd = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++;
    if ({out_ctl, out_op1, out_op2, out_rd} !== '0)
      begin n_fail++; $display("FAIL reset_outs got %h/%h/%h/%h want 0", out_ctl, out_op1, out_op2, out_rd); end
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h0097423B; tick();
    wb_rd = 5'd6; wb_data = 32'h014872C1; tick();
    wb_en = 1'b0;
    out_ready = 1'b1;
    set_op(ALU_CTL_ADD, 5'd5, 5'd6, 1'b0, $urandom, 5'd7);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid got %b want 1", out_valid); end
    n_checks++;
    if (out_op1 !== 32'h0097423B) begin n_fail++; $display("FAIL add_op1 got %h want 0097423b", out_op1); end
    n_checks++;
    if (out_op2 !== 32'h014872C1) begin n_fail++; $display("FAIL add_op2 got %h want 014872c1", out_op2); end
    n_checks++;
    if (out_op1 + out_op2 !== 32'h01DFB4FC) begin n_fail++; $display("FAIL add_res got %h want 01dfb4fc", out_op1 + out_op2); end
    n_checks++;
    if ({out_ctl, out_rd} !== {ALU_CTL_ADD, 5'd7}) begin n_fail++; $display("FAIL add_ctl_rd got %h/%0d want %h/7", out_ctl, out_rd, ALU_CTL_ADD); end
    tick();
  endtask

  task automatic test_imm();
    out_ready = 1'b1;
    set_op(ALU_CTL_SLL, 5'd5, 5'd6, 1'b1, 32'h00000007, 5'd3);
    tick();
    set_op(ALU_CTL_SLL, 5'd0, 5'd6, 1'b1, 32'h00000007, 5'd4);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL imm_in_ready got %b want 1", in_ready); end
    n_checks++;
    if ({out_op1, out_op2} !== {32'h0097423B, 32'h00000007})
      begin n_fail++; $display("FAIL imm_ops got %h/%h want 0097423b/00000007", out_op1, out_op2); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_op1, out_op2, out_rd} !== {1'b1, 32'h0, 32'h00000007, 5'd4})
      begin n_fail++; $display("FAIL imm_x0 got v=%b %h/%h rd=%0d want 1 0/7 rd=4", out_valid, out_op1, out_op2, out_rd); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [CTLW+2*XLEN+AW-1:0] snap;
    int drained;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_op(CTLW'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), $urandom, 5'($urandom));
      n_checks++;
      if (in_ready !== (k < 2)) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want %b", k, in_ready, k < 2); end
      tick();
    end
    in_valid = 1'b0;
    snap = {out_ctl, out_op1, out_op2, out_rd};
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({in_ready, out_valid} !== 2'b01) begin n_fail++; $display("FAIL bp_full got rdy=%b vld=%b want 0/1", in_ready, out_valid); end
      n_checks++;
      if (snap !== {q[0].ctl, q[0].op1, q[0].op2, q[0].rd}) begin n_fail++; $display("FAIL bp_head got %h want %h", snap, {q[0].ctl, q[0].op1, q[0].op2, q[0].rd}); end
      tick();
      n_checks++;
      if ({out_ctl, out_op1, out_op2, out_rd} !== snap) begin n_fail++; $display("FAIL bp_stable got %h want %h", {out_ctl, out_op1, out_op2, out_rd}, snap); end
    end
    out_ready = 1'b1;
    drained = 0;
    for (int k = 0; k < 4; k++) begin
      if (out_valid === 1'b1 && q.size() > 0) begin
        n_checks++;
        if ({out_ctl, out_op1, out_op2, out_rd} !== {q[0].ctl, q[0].op1, q[0].op2, q[0].rd})
          begin n_fail++; $display("FAIL bp_order[%0d] got %h want %h", drained, {out_ctl, out_op1, out_op2, out_rd}, {q[0].ctl, q[0].op1, q[0].op2, q[0].rd}); end
        drained++;
      end
      tick();
    end
    n_checks++;
    if (drained != 2 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_count got %0d vld=%b want 2 vld=0", drained, out_valid); end
  endtask

  task automatic test_x0_write();
    out_ready = 1'b1;
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF; tick();
    wb_en = 1'b0;
    set_op(ALU_CTL_OR, 5'd0, 5'd0, 1'b0, 32'h12345678, 5'd9);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_op1, out_op2} !== {1'b1, 32'h0, 32'h0})
      begin n_fail++; $display("FAIL x0_read got v=%b %h/%h want 1 0/0", out_valid, out_op1, out_op2); end
    tick();
  endtask

  task automatic test_wb_hazard();
    out_ready = 1'b0;
    set_op(ALU_CTL_ADD, 5'd5, 5'd6, 1'b0, 32'h0, 5'd1);
    tick();
    set_op(ALU_CTL_ADD, 5'd5, 5'd0, 1'b1, 32'h0, 5'd2);
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h8CBDA0FC;
    tick();
    in_valid = 1'b0; wb_en = 1'b0;
    n_checks++;
    if ({out_op1, out_rd} !== {HAZ_EXP, 5'd1}) begin n_fail++; $display("FAIL haz_head got %h rd=%0d want %h rd=1", out_op1, out_rd, HAZ_EXP); end
    out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, out_op1, out_rd} !== {1'b1, HAZ_EXP, 5'd2}) begin n_fail++; $display("FAIL haz_skid got v=%b %h rd=%0d want 1 %h rd=2", out_valid, out_op1, out_rd, HAZ_EXP); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_ctl = CTLW'($urandom); in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
      in_use_imm = 1'($urandom); in_imm = $urandom; in_rd = 5'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      wb_en = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      n_checks++;
      if ({in_ready, out_valid} !== {q.size() < 2, q.size() > 0})
        begin n_fail++; $display("FAIL rnd_flags[%0d] got rdy=%b vld=%b want %b/%b", c, in_ready, out_valid, q.size() < 2, q.size() > 0); end
      if (q.size() > 0) begin
        n_checks++;
        if ({out_ctl, out_op1, out_op2, out_rd} !== {q[0].ctl, q[0].op1, q[0].op2, q[0].rd})
          begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", c, {out_ctl, out_op1, out_op2, out_rd}, {q[0].ctl, q[0].op1, q[0].op2, q[0].rd}); end
      end
      tick();
    end
    in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hA5A5A5A5; tick();
    wb_en = 1'b0;
    set_op(ALU_CTL_XOR, 5'd5, 5'd5, 1'b0, 32'h0, 5'd8); tick();
    set_op(ALU_CTL_SUB, 5'd5, 5'd1, 1'b1, 32'h5, 5'd9); tick();
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b01) begin n_fail++; $display("FAIL rstm_full got rdy=%b vld=%b want 0/1", in_ready, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL rstm_async got rdy=%b vld=%b want 1/0", in_ready, out_valid); end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    n_checks++;
    if ({in_ready, out_valid, out_ctl, out_op1, out_op2, out_rd} !== {1'b1, 1'b0, {(CTLW+2*XLEN+AW){1'b0}}})
      begin n_fail++; $display("FAIL rstm_outs got rdy=%b vld=%b %h/%h/%h/%h want 1/0 zeros", in_ready, out_valid, out_ctl, out_op1, out_op2, out_rd); end
    set_op(ALU_CTL_ADD, 5'd5, 5'd5, 1'b0, 32'h0, 5'd1);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, out_op1, out_op2} !== {1'b1, 32'h0, 32'h0})
      begin n_fail++; $display("FAIL rstm_rf_clear got v=%b %h/%h want 1 0/0", out_valid, out_op1, out_op2); end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_backpressure();
    test_x0_write();
    test_wb_hazard();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
